// File: rtl/wb_arb2_rr.sv
// rtl/wb_arb2_rr.sv - two-master round-robin Wishbone B3 arbiter with bus watchdog
module wb_arb2_rr #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic [2*AW-1:0]       m_adr_i,
    input  logic [2*DW-1:0]       m_dat_i,
    input  logic [2*(DW/8)-1:0]   m_sel_i,
    input  logic [1:0]            m_we_i,
    input  logic [1:0]            m_cyc_i,
    input  logic [1:0]            m_stb_i,
    input  logic [5:0]            m_cti_i,
    input  logic [3:0]            m_bte_i,
    output logic [DW-1:0]         m_dat_o,
    output logic [1:0]            m_ack_o,
    output logic [1:0]            m_err_o,
    output logic [1:0]            m_rty_o,
    output logic [AW-1:0]         s_adr_o,
    output logic [DW-1:0]         s_dat_o,
    output logic [DW/8-1:0]       s_sel_o,
    output logic                  s_we_o,
    output logic                  s_cyc_o,
    output logic                  s_stb_o,
    output logic [2:0]            s_cti_o,
    output logic [1:0]            s_bte_o,
    input  logic [DW-1:0]         s_dat_i,
    input  logic                  s_ack_i,
    input  logic                  s_err_i,
    input  logic                  s_rty_i,
    output logic [1:0]            grant_o,
    output logic                  wdt_o
);

    localparam int SW = DW / 8;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit WDT_EN = (TIMEOUT != 0);
    localparam logic [CW-1:0] WDT_LIM = CW'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t          state, state_nxt;
    logic            last_owner, last_owner_nxt;
    logic [CW-1:0]   wdt_cnt;
    logic            owner, owned, stb_raw, slv_term, wdt_fire;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state      <= IDLE;
            last_owner <= 1'b1;
            wdt_cnt    <= '0;
        end else begin
            state      <= state_nxt;
            last_owner <= last_owner_nxt;
            // Any termination, idle strobe, firing or ownership change restarts the stall count
            if (!stb_raw || slv_term || wdt_fire || (state_nxt != state))
                wdt_cnt <= '0;
            else if (wdt_cnt != {CW{1'b1}})
                wdt_cnt <= wdt_cnt + 1'b1;
        end
    end

    always_comb begin
        owner    = (state == OWN1);
        owned    = (state != IDLE);
        slv_term = s_ack_i | s_err_i | s_rty_i;

        // Master 0 fields are routed whenever master 1 does not own the bus
        s_adr_o  = owner ? m_adr_i[AW +: AW] : m_adr_i[0 +: AW];
        s_dat_o  = owner ? m_dat_i[DW +: DW] : m_dat_i[0 +: DW];
        s_sel_o  = owner ? m_sel_i[SW +: SW] : m_sel_i[0 +: SW];
        s_we_o   = owner ? m_we_i[1]         : m_we_i[0];
        s_cti_o  = owner ? m_cti_i[5:3]      : m_cti_i[2:0];
        s_bte_o  = owner ? m_bte_i[3:2]      : m_bte_i[1:0];
        s_cyc_o  = owned & (owner ? m_cyc_i[1] : m_cyc_i[0]);
        stb_raw  = s_cyc_o & (owner ? m_stb_i[1] : m_stb_i[0]);

        // A slave termination in the firing cycle wins over the watchdog
        wdt_fire = WDT_EN && stb_raw && !slv_term && (wdt_cnt == WDT_LIM);
        s_stb_o  = stb_raw & ~wdt_fire;
        wdt_o    = wdt_fire;
        m_dat_o  = s_dat_i;

        m_ack_o  = 2'b00;
        m_err_o  = 2'b00;
        m_rty_o  = 2'b00;
        if (owned) begin
            m_ack_o[owner] = s_ack_i & s_cyc_o;
            m_rty_o[owner] = s_rty_i & s_cyc_o;
            m_err_o[owner] = (s_err_i & s_cyc_o) | wdt_fire;
        end

        grant_o        = {state == OWN1, state == OWN0};
        state_nxt      = state;
        last_owner_nxt = last_owner;
        case (state)
            IDLE: begin
                if (m_cyc_i == 2'b11)
                    state_nxt = last_owner ? OWN0 : OWN1;
                else if (m_cyc_i[0])
                    state_nxt = OWN0;
                else if (m_cyc_i[1])
                    state_nxt = OWN1;
            end
            OWN0: begin
                if (!m_cyc_i[0]) begin
                    last_owner_nxt = 1'b0;
                    state_nxt      = m_cyc_i[1] ? OWN1 : IDLE;
                end
            end
            OWN1: begin
                if (!m_cyc_i[1]) begin
                    last_owner_nxt = 1'b1;
                    state_nxt      = m_cyc_i[0] ? OWN0 : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
